// File: rtl/num_pkg.sv
// Shared encodings for the divisor-sum classifier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package num_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_ACC  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] CLS_DEF  = 2'b00;
  localparam logic [1:0] CLS_PERF = 2'b01;
  localparam logic [1:0] CLS_ABUN = 2'b10;
  localparam logic [1:0] CLS_INV  = 2'b11;

endpackage

// File: rtl/rem_unit.sv
// Restoring remainder divider: rem = dividend mod divisor.
// Latency: the start edge performs the first step; ready is visible WIDTH cycles after start is asserted.
// Backpressure: none; a new start restarts it, the result is held until the next start.
module rem_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             act_q, act_d, rdy_q, rdy_d;

  logic [WIDTH-1:0] src_r, src_q, src_dvs, step_r;
  logic [WIDTH:0]   trial;

  // One restoring step; on start it works on the freshly presented operands.
  always_comb begin
    src_r   = start ? '0 : r_q;
    src_q   = start ? dividend : q_q;
    src_dvs = start ? divisor : dvs_q;
    trial   = {src_r, src_q[WIDTH-1]};
    if (trial >= {1'b0, src_dvs}) begin
      step_r = WIDTH'(trial - {1'b0, src_dvs});
    end else begin
      step_r = trial[WIDTH-1:0];
    end
  end

  // Sequencing: load on start, then WIDTH-1 further steps, then flag ready.
  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    act_d = act_q;
    rdy_d = rdy_q;
    if (start) begin
      r_d   = step_r;
      q_d   = {src_q[WIDTH-2:0], 1'b0};
      dvs_d = divisor;
      cnt_d = CW'(WIDTH - 1);
      act_d = 1'b1;
      rdy_d = 1'b0;
    end else if (act_q) begin
      r_d   = step_r;
      q_d   = {q_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        act_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  // Divider state registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      rdy_q <= rdy_d;
    end
  end

  assign ready = rdy_q;
  assign rem   = r_q;

endmodule

// File: rtl/num_classify.sv
// Sums proper divisors of a latched operand by trial division and classifies it deficient/perfect/abundant.
// Latency: K*(WIDTH+1)+1 cycles from the accepted go, K = last candidate divisor tried (0 for n<2).
// Backpressure: go is accepted only when idle or done; go while busy is ignored.
module num_classify
  import num_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 0,
  parameter int SUMW       = WIDTH + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] sw,
  output logic             busy,
  output logic             over,
  output logic             ans,
  output logic [1:0]       cls,
  output logic [SUMW-1:0]  div_sum,
  output logic [SUMW-1:0]  div_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, d_q, d_d;
  logic [SUMW-1:0]  sum_q, sum_d, cnt_q, cnt_d;
  logic             busy_q, busy_d, over_q, over_d, ans_q, ans_d;
  logic [1:0]       cls_q, cls_d;
  logic [SUMW-1:0]  div_sum_q, div_sum_d, div_cnt_q, div_cnt_d;

  logic             div_start, div_rdy;
  logic [WIDTH-1:0] rem;
  logic [SUMW-1:0]  n_ext, d_ext;

  assign n_ext = {{(SUMW-WIDTH){1'b0}}, n_q};
  assign d_ext = {{(SUMW-WIDTH){1'b0}}, d_q};

  // The divider is loaded with the next-state operand and candidate, so it starts on the same edge the FSM enters DIV.
  rem_unit #(.WIDTH(WIDTH)) u_rem (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (n_d),
    .divisor  (d_d),
    .ready    (div_rdy),
    .rem      (rem)
  );

  // Next-state, accumulation and result logic.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    over_d    = over_q;
    ans_d     = ans_q;
    cls_d     = cls_q;
    div_sum_d = div_sum_q;
    div_cnt_d = div_cnt_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          n_d    = sw;
          d_d    = WIDTH'(1);
          sum_d  = '0;
          cnt_d  = '0;
          over_d = 1'b0;
          busy_d = 1'b1;
          if (sw >= WIDTH'(2)) begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end else begin
            state_d = ST_CMP;
          end
        end
      end
      ST_DIV: begin
        if (div_rdy) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (rem == '0) begin
          sum_d = sum_q + d_ext;
          cnt_d = cnt_q + SUMW'(1);
        end
        d_d = d_q + WIDTH'(1);
        if ((d_q == (n_q >> 1)) || ((EARLY_EXIT != 0) && (sum_d > n_ext))) begin
          state_d = ST_CMP;
        end else begin
          state_d   = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_CMP: begin
        if (n_q == '0)          cls_d = CLS_INV;
        else if (sum_q < n_ext) cls_d = CLS_DEF;
        else if (sum_q == n_ext) cls_d = CLS_PERF;
        else                    cls_d = CLS_ABUN;
        ans_d     = (cls_d == CLS_PERF);
        div_sum_d = sum_q;
        div_cnt_d = cnt_q;
        busy_d    = 1'b0;
        over_d    = 1'b1;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset returns to IDLE and clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      d_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
      ans_q     <= 1'b0;
      cls_q     <= CLS_DEF;
      div_sum_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      d_q       <= d_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      over_q    <= over_d;
      ans_q     <= ans_d;
      cls_q     <= cls_d;
      div_sum_q <= div_sum_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign over    = over_q;
  assign ans     = ans_q;
  assign cls     = cls_q;
  assign div_sum = div_sum_q;
  assign div_cnt = div_cnt_q;

endmodule

// File: tb/tb_num_classify.sv
// Scoreboard bench for num_classify across three configurations.
// Instances: 0 = WIDTH 16, 1 = WIDTH 16 with early exit, 2 = WIDTH 8.
// Expected results come from a plain divisor-enumeration model.
module tb_num_classify;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  go;
  logic [15:0] sw [3];
  logic [2:0]  busy, over, ans;
  logic [1:0]  cls [3];
  logic [18:0] sum0, sum1, cnt0, cnt1;
  logic [10:0] sum2, cnt2;

  num_classify #(.WIDTH(16), .EARLY_EXIT(0)) u_w16 (
    .clk(clk), .rst(rst), .go(go[0]), .sw(sw[0]), .busy(busy[0]), .over(over[0]),
    .ans(ans[0]), .cls(cls[0]), .div_sum(sum0), .div_cnt(cnt0));

  num_classify #(.WIDTH(16), .EARLY_EXIT(1)) u_w16e (
    .clk(clk), .rst(rst), .go(go[1]), .sw(sw[1]), .busy(busy[1]), .over(over[1]),
    .ans(ans[1]), .cls(cls[1]), .div_sum(sum1), .div_cnt(cnt1));

  num_classify #(.WIDTH(8), .EARLY_EXIT(0)) u_w8 (
    .clk(clk), .rst(rst), .go(go[2]), .sw(sw[2][7:0]), .busy(busy[2]), .over(over[2]),
    .ans(ans[2]), .cls(cls[2]), .div_sum(sum2), .div_cnt(cnt2));

  typedef struct {
    int     inst;
    int     n;
    int     cls;
    int     sum;
    int     cnt;
    int     lat;
    longint e0;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic [2:0] prev_over = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint out_sum(int i);
    case (i)
      0:       return longint'(sum0);
      1:       return longint'(sum1);
      default: return longint'(sum2);
    endcase
  endfunction

  function automatic longint out_cnt(int i);
    case (i)
      0:       return longint'(cnt0);
      1:       return longint'(cnt1);
      default: return longint'(cnt2);
    endcase
  endfunction

  // Reference: enumerate candidates 1..n/2, stop early once the sum passes n when enabled.
  function automatic exp_t model(int inst, int n);
    exp_t e;
    int w  = (inst == 2) ? 8 : 16;
    int ee = (inst == 1) ? 1 : 0;
    int k  = 0;
    e.inst = inst;
    e.n    = n;
    e.sum  = 0;
    e.cnt  = 0;
    e.e0   = 0;
    if (n >= 2) begin
      for (int d = 1; d <= n / 2; d++) begin
        k = d;
        if (n % d == 0) begin
          e.sum += d;
          e.cnt += 1;
        end
        if (ee == 1 && e.sum > n) break;
      end
    end
    if (n == 0)         e.cls = 3;
    else if (e.sum < n) e.cls = 0;
    else if (e.sum == n) e.cls = 1;
    else                e.cls = 2;
    e.lat = k * (w + 1) + 1;
    return e;
  endfunction

  // Monitor: on every rising over, pop the oldest expectation and compare.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (over[i] && !prev_over[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_over inst %0d", i);
        end else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("inst n=%0d", mon_e.n), i, mon_e.inst);
          chk($sformatf("cls inst%0d n=%0d", i, mon_e.n), longint'(cls[i]), mon_e.cls);
          chk($sformatf("div_sum inst%0d n=%0d", i, mon_e.n), out_sum(i), mon_e.sum);
          chk($sformatf("div_cnt inst%0d n=%0d", i, mon_e.n), out_cnt(i), mon_e.cnt);
          chk($sformatf("latency inst%0d n=%0d", i, mon_e.n), cyc - mon_e.e0, mon_e.lat);
          chk($sformatf("busy_low inst%0d n=%0d", i, mon_e.n), longint'(busy[i]), 0);
          chk($sformatf("ans inst%0d n=%0d", i, mon_e.n), longint'(ans[i]), (mon_e.cls == 1) ? 1 : 0);
        end
      end
    end
    prev_over = over;
  end

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending %0d", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(int inst, int n, bit expect_result);
    exp_t e;
    e = model(inst, n);
    @(negedge clk);
    sw[inst] = 16'(n);
    go[inst] = 1'b1;
    e.e0 = cyc + 1;
    if (expect_result) exp_q.push_back(e);
    @(negedge clk);
    go[inst] = 1'b0;
  endtask

  task automatic run(int inst, int n);
    issue(inst, n, 1'b1);
    wait_done();
  endtask

  task automatic check_zero(int i, string tag);
    chk($sformatf("%s busy inst%0d", tag, i), longint'(busy[i]), 0);
    chk($sformatf("%s over inst%0d", tag, i), longint'(over[i]), 0);
    chk($sformatf("%s ans inst%0d", tag, i), longint'(ans[i]), 0);
    chk($sformatf("%s cls inst%0d", tag, i), longint'(cls[i]), 0);
    chk($sformatf("%s div_sum inst%0d", tag, i), out_sum(i), 0);
    chk($sformatf("%s div_cnt inst%0d", tag, i), out_cnt(i), 0);
  endtask

  initial begin
    rst = 1'b0;
    go  = 3'b000;
    for (int i = 0; i < 3; i++) sw[i] = 16'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    run(0, 6);
    run(0, 120);
    run(1, 120);
    run(0, 0);
    run(0, 1);
    run(1, 0);
    run(2, 255);
    run(2, 28);
    run(1, 28);
    run(0, 2);
    run(0, 3);

    // Randomised operands, kept small enough for short runs on the 16-bit instances.
    for (int k = 0; k < 6; k++) begin
      run(0, int'($urandom_range(0, 300)));
      run(1, int'($urandom_range(0, 300)));
      run(2, int'($urandom_range(0, 255)));
    end

    // A go pulse in the middle of a run must not disturb it.
    issue(2, 28, 1'b1);
    repeat (20) @(negedge clk);
    sw[2] = 16'd6;
    go[2] = 1'b1;
    @(negedge clk);
    go[2] = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of a run clears everything at once.
    issue(2, 28, 1'b0);
    repeat (25) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero(2, "midrun_reset");
    @(negedge clk);
    check_zero(2, "held_reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(2, "after_release");
    run(2, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
